mul_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one fully pipelined 32-bit multiplier (`Mul`, fixed 11-cycle latency, no stall, no valid) among `N` requesters. It grants at most one request per cycle and drives the selected operands onto the multiplier ports. A shadow valid/tag pipeline of depth `LATENCY` routes each product back to its requester. It sits between the requesting datapath units and a single `Mul` instance, which is instantiated outside this block.

---
 rtl/mul_rr_scheduler.sv | 119 +++++++++++
 tb/tb_mul_rr_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end for one shared, fixed-latency, non-stalling 32-bit multiplier.
// A shadow valid/id pipeline matched to the multiplier latency routes products back.
module mul_rr_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned LATENCY = 11,
  parameter int unsigned IDW     = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0]                 req_valid,
  input  logic [32*N-1:0]              req_a,
  input  logic [32*N-1:0]              req_b,
  output logic [N-1:0]                 req_ready,
  output logic [31:0]                  mul_a,
  output logic [31:0]                  mul_b,
  input  logic [31:0]                  mul_out,
  output logic [N-1:0]                 resp_valid,
  output logic [31:0]                  resp_data,
  output logic [IDW-1:0]               resp_id,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic                         idle
);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic               xfer;
  logic               resp_on;
  logic [LATENCY-1:0] vld_q;
  logic [IDW-1:0]     id_q [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;

  // Two passes: indices at or above ptr first, then the wrapped-around lower indices.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req_valid[i] && (IDW'(i) >= ptr_q)) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end

  assign xfer = gnt_any && !reset;

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (xfer && (gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[32*i +: 32];
        mul_b        = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Gating with reset keeps stale stages from showing during the reset cycle itself.
  assign resp_on = vld_q[LATENCY-1] && !reset;

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (resp_on && (id_q[LATENCY-1] == IDW'(i))) begin
        resp_valid[i] = 1'b1;
      end
    end
    resp_id   = resp_on ? id_q[LATENCY-1] : '0;
    resp_data = resp_on ? mul_out : '0;
  end

  always_comb begin
    case ({xfer, resp_on})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign inflight = reset ? '0 : cnt_q;
  assign idle     = (inflight == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      vld_q[0] <= xfer;
      id_q[0]  <= xfer ? gnt_id : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: directed phases plus random traffic, checked against a
// queue-based model of round-robin grant order and fixed-latency product return.
module tb_mul_rr_scheduler;
  localparam int N   = 4;
  localparam int LAT = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [31:0]     mul_out;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic [1:0]      resp_id;
  logic [3:0]      inflight;
  logic            idle;

  always #5 clk = ~clk;

  mul_rr_scheduler #(.N(N), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_out    (mul_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .inflight   (inflight),
    .idle       (idle)
  );

  // Stand-in for the external fixed-latency multiplier.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  int          ptr_m;
  int          cyc;
  bit          pend_v [N];
  logic [31:0] pend_a [N];
  logic [31:0] pend_b [N];
  int          checks;
  int          failures;
  int          max_infl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive requests, predict, sample at negedge, then advance the model.
  task automatic step();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    logic [31:0]  e_a, e_b, e_d, prod;
    int           e_id, e_inf, gid, j;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend_v[i];
      req_a[32*i +: 32]   = pend_a[i];
      req_b[32*i +: 32]   = pend_b[i];
    end
    gid = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        j = (ptr_m + k) % N;
        if (gid < 0 && pend_v[j]) gid = j;
      end
    end
    e_rdy = '0; e_a = '0; e_b = '0;
    if (gid >= 0) begin
      e_rdy[gid] = 1'b1;
      e_a = pend_a[gid];
      e_b = pend_b[gid];
    end
    e_rv = '0; e_id = 0; e_d = '0;
    if (!reset && q.size() > 0 && q[0].due == cyc) begin
      e_rv[q[0].id] = 1'b1;
      e_id = q[0].id;
      e_d  = q[0].data;
    end
    e_inf = reset ? 0 : q.size();
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mul_a", mul_a, e_a);
    chk("mul_b", mul_b, e_b);
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("resp_id", 32'(resp_id), 32'(e_id));
    chk("resp_data", resp_data, e_d);
    chk("inflight", 32'(inflight), 32'(e_inf));
    chk("idle", 32'(idle), 32'(e_inf == 0));
    if (int'(inflight) > max_infl) max_infl = int'(inflight);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      ptr_m = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (gid >= 0) begin
        prod = pend_a[gid] * pend_b[gid];
        q.push_back('{due: cyc + LAT, id: gid, data: prod});
        ptr_m = (gid + 1) % N;
        pend_v[gid] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; ptr_m = 0; max_infl = 0;
    reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0;
    end
    @(posedge clk);
    #1;
    // Reset held with a request pending: no grant, all outputs quiet.
    pend_v[1] = 1'b1; pend_a[1] = 32'd3; pend_b[1] = 32'd3;
    drain(2);
    pend_v[1] = 1'b0;
    reset = 1'b0;
    drain(3);

    // Single op on requester 2: 7*6.
    pend_v[2] = 1'b1; pend_a[2] = 32'd7; pend_b[2] = 32'd6;
    drain(14);

    // Contention: all requesters continuously valid, a=i+1, b=10.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i]) begin
          pend_v[i] = 1'b1; pend_a[i] = 32'(i + 1); pend_b[i] = 32'd10;
        end
      end
      step();
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    drain(13);

    // Full throughput: requester 1 alone squares 1..20 back to back.
    max_infl = 0;
    for (int k = 1; k <= 20; k++) begin
      pend_v[1] = 1'b1; pend_a[1] = 32'(k); pend_b[1] = 32'(k);
      step();
    end
    drain(13);
    chk("peak_inflight", 32'(max_infl), 32'd11);

    // Wrap: requesters 0 and 3 valid while the pointer sits at 3.
    pend_v[2] = 1'b1; pend_a[2] = 32'd5; pend_b[2] = 32'd5;
    step();
    pend_v[0] = 1'b1; pend_a[0] = 32'd9;  pend_b[0] = 32'd9;
    pend_v[3] = 1'b1; pend_a[3] = 32'd11; pend_b[3] = 32'd4;
    drain(2);

    // Truncation to the low 32 bits.
    pend_v[0] = 1'b1; pend_a[0] = 32'hFFFF_FFFF; pend_b[0] = 32'd2;
    drain(13);

    // Reset mid-flight: five ops issued, then reset discards them.
    for (int k = 0; k < 5; k++) begin
      pend_v[3] = 1'b1; pend_a[3] = 32'(100 + k); pend_b[3] = 32'd3;
      step();
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain(15);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 2) == 0)) begin
          pend_v[i] = 1'b1;
          pend_a[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          pend_b[i] = $urandom;
        end
      end
      step();
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    drain(13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
